// File: rtl/vctr_drv_pkg.sv
// rtl/vctr_drv_pkg.sv - shared FSM state type and counter sizing for the vector stream driver
package vctr_drv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        PUSH,
        WAIT_DONE,
        DRAIN,
        FINISH
    } state_t;

    function automatic int cnt_width(input int vector_length);
        return $clog2(2 * vector_length) + 1;
    endfunction

endpackage

// File: rtl/vctr_drv_addr_gen.sv
// rtl/vctr_drv_addr_gen.sv - element index counter with split two-base address adder and last flag
module vctr_drv_addr_gen #(
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_W      = 5,
    parameter int SPLIT      = 8,
    parameter int LAST       = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inc,
    input  logic [ADDR_WIDTH-1:0] base_lo,
    input  logic [ADDR_WIDTH-1:0] base_hi,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] off;
    logic             lo;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + CNT_W'(1);
        end
    end

    // Indices below SPLIT address base_lo; the rest restart from base_hi.
    assign lo   = idx < CNT_W'(SPLIT);
    assign off  = lo ? idx : idx - CNT_W'(SPLIT);
    assign addr = (lo ? base_lo : base_hi) + ADDR_WIDTH'(off);
    assign last = idx == CNT_W'(LAST);

endmodule

// File: rtl/vctr_stream_driver.sv
// rtl/vctr_stream_driver.sv - SRAM-to-accelerator vector stream initiator; watchdog under VCTR_DRV_TIMEOUT_EN
module vctr_stream_driver
    import vctr_drv_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int VECTOR_LENGTH  = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base_a,
    input  logic [ADDR_WIDTH-1:0] cmd_base_b,
    input  logic [ADDR_WIDTH-1:0] cmd_base_out,
    output logic                  cmd_done,
    output logic                  err_timeout,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  acc_start,
    input  logic                  acc_idle,
    input  logic                  acc_ready,
    input  logic                  acc_done,
    output logic                  acc_data_in_en,
    output logic [DATA_WIDTH-1:0] acc_data_in,
    output logic                  acc_data_out_en,
    input  logic [DATA_WIDTH-1:0] acc_data_out
);

    localparam int              CW        = cnt_width(VECTOR_LENGTH);
    localparam logic [CW-1:0]   PUSH_LAST = CW'(2 * VECTOR_LENGTH - 1);
    localparam logic [CW-1:0]   POP_LAST  = CW'(VECTOR_LENGTH - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_a, base_b, base_out;
    logic [CW-1:0]         cnt;
    logic                  started, rd_pend, rd_all, hold_vld, wr_en_q;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  accept, rd_issue, push, rd_last, wr_last, timeout_fire;
    logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;

    assign accept   = (state == IDLE) && cmd_valid && cmd_ready;
    // A read whose data arrives while acc_ready is low is parked in hold_data;
    // no new read is issued until it has been pushed, so one entry suffices.
    assign rd_issue = (state == PUSH) && acc_ready && !rd_all;
    assign push     = (state == PUSH) && acc_ready && (rd_pend || hold_vld);

    assign mem_rd_en      = rd_issue;
    assign mem_rd_addr    = rd_issue ? rd_addr : '0;
    assign acc_data_in_en = push;
    assign acc_data_in    = push ? (hold_vld ? hold_data : mem_rd_data) : '0;
    assign mem_wr_en      = wr_en_q;
    assign mem_wr_addr    = wr_en_q ? wr_addr : '0;
    assign mem_wr_data    = wr_en_q ? acc_data_out : '0;

    vctr_drv_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_W      (CW),
        .SPLIT      (VECTOR_LENGTH),
        .LAST       (2 * VECTOR_LENGTH - 1)
    ) u_rd_gen (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .inc     (rd_issue),
        .base_lo (base_a),
        .base_hi (base_b),
        .addr    (rd_addr),
        .last    (rd_last)
    );

    vctr_drv_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_W      (CW),
        .SPLIT      (VECTOR_LENGTH),
        .LAST       (VECTOR_LENGTH - 1)
    ) u_wr_gen (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .inc     (wr_en_q),
        .base_lo (base_out),
        .base_hi (base_out),
        .addr    (wr_addr),
        .last    (wr_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cmd_ready       <= 1'b1;
            cmd_done        <= 1'b0;
            acc_start       <= 1'b0;
            acc_data_out_en <= 1'b0;
            wr_en_q         <= 1'b0;
            started         <= 1'b0;
            rd_pend         <= 1'b0;
            rd_all          <= 1'b0;
            hold_vld        <= 1'b0;
            hold_data       <= '0;
            cnt             <= '0;
            base_a          <= '0;
            base_b          <= '0;
            base_out        <= '0;
        end else begin
            cmd_done  <= 1'b0;
            acc_start <= 1'b0;
            wr_en_q   <= acc_data_out_en;
            rd_pend   <= rd_issue;
            if (rd_issue && rd_last) begin
                rd_all <= 1'b1;
            end
            if (rd_pend && !push) begin
                hold_vld  <= 1'b1;
                hold_data <= mem_rd_data;
            end else if (push && hold_vld) begin
                hold_vld <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        base_a    <= cmd_base_a;
                        base_b    <= cmd_base_b;
                        base_out  <= cmd_base_out;
                        cmd_ready <= 1'b0;
                        started   <= 1'b0;
                        rd_all    <= 1'b0;
                        cnt       <= '0;
                        state     <= START;
                    end
                end
                START: begin
                    if (!started) begin
                        if (acc_idle) begin
                            acc_start <= 1'b1;
                            started   <= 1'b1;
                        end
                    end else if (acc_ready) begin
                        cnt   <= '0;
                        state <= PUSH;
                    end
                end
                PUSH: begin
                    if (push) begin
                        if (cnt == PUSH_LAST) begin
                            cnt   <= '0;
                            state <= WAIT_DONE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                WAIT_DONE: begin
                    if (acc_done) begin
                        acc_data_out_en <= 1'b1;
                        cnt             <= '0;
                        state           <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (acc_data_out_en) begin
                        if (cnt == POP_LAST) begin
                            acc_data_out_en <= 1'b0;
                        end
                        cnt <= cnt + CW'(1);
                    end
                    if (wr_en_q && wr_last) begin
                        cmd_done <= 1'b1;
                        state    <= FINISH;
                    end
                end
                FINISH: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (timeout_fire) begin
                state           <= IDLE;
                cmd_ready       <= 1'b1;
                cmd_done        <= 1'b1;
                acc_start       <= 1'b0;
                acc_data_out_en <= 1'b0;
                wr_en_q         <= 1'b0;
            end
        end
    end

`ifdef VCTR_DRV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        last_state;
    logic [TW-1:0] tcnt, age;
    logic          watched;

    // age is the number of cycles already spent in the current state.
    assign watched      = (state == START) || (state == WAIT_DONE) || (state == DRAIN);
    assign age          = (state != last_state) ? '0 : tcnt;
    assign timeout_fire = watched && (age == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            last_state  <= IDLE;
            tcnt        <= '0;
            err_timeout <= 1'b0;
        end else begin
            last_state <= state;
            tcnt       <= watched ? age + TW'(1) : '0;
            if (timeout_fire) begin
                err_timeout <= 1'b1;
            end else if (accept) begin
                err_timeout <= 1'b0;
            end
        end
    end
`else
    assign timeout_fire = 1'b0;
    assign err_timeout  = 1'b0;
`endif

endmodule
